// File: rtl/keccak_chi_inv_pkg.sv
// Shared types and row-level chi helpers for the iterative chi inverse.
package keccak_pkg;

  localparam int unsigned LANES = 5;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_e;

  // Forward chi on one 5-bit row: bit i = a[i] ^ (~a[i+1] & a[i+2]), indices mod 5.
  function automatic logic [4:0] row_chi(input logic [4:0] a);
    return a ^ (~{a[0], a[4:1]} & {a[1:0], a[4:2]});
  endfunction

  // Row chi is a bijection, so exactly one of the 32 candidates matches.
  function automatic logic [4:0] row_chi_inv(input logic [4:0] y);
    logic [4:0] x;
    x = '0;
    for (int unsigned c = 0; c < 32; c++) begin
      if (row_chi(5'(c)) == y) x = 5'(c);
    end
    return x;
  endfunction

endpackage

// File: rtl/keccak_chi_inv_if.sv
// Input/output handshake bundle for keccak_chi_inv.
interface keccak_chi_inv_if
  import keccak_pkg::*;
#(
  parameter int unsigned L = 6
);
  localparam int unsigned W = 1 << L;
  localparam int unsigned B = LANES * LANES * W;

  logic [B-1:0] in_data;
  logic         in_valid;
  logic         in_ready;
  logic [B-1:0] out_data;
  logic         out_valid;
  logic         out_ready;
  logic         busy;

  modport master (
    output in_data, in_valid, out_ready,
    input  in_ready, out_data, out_valid, busy
  );

  modport slave (
    input  in_data, in_valid, out_ready,
    output in_ready, out_data, out_valid, busy
  );

endinterface

// File: rtl/keccak_chi_inv_row.sv
// 5-bit row inverse of chi; table entries are found by search at elaboration.
module keccak_chi_inv_row
  import keccak_pkg::*;
(
  input  logic [4:0] y_i,
  output logic [4:0] x_o
);

  logic [4:0] lut [32];

  for (genvar c = 0; c < 32; c++) begin : g_lut
    assign lut[c] = row_chi_inv(5'(c));
  end

  assign x_o = lut[y_i];

endmodule

// File: rtl/keccak_chi_inv.sv
// Iterative Keccak chi inverse, one 5-lane slice per cycle.
// Optional KECCAK_CHI_INV_SELFCHECK_EN adds chk_err (forward chi re-check).
module keccak_chi_inv
  import keccak_pkg::*;
#(
  parameter int unsigned L = 6
) (
  input  logic             clk,
  input  logic             rst_n,
  keccak_chi_inv_if.slave  bus
`ifdef KECCAK_CHI_INV_SELFCHECK_EN
  ,
  output logic             chk_err
`endif
);

  localparam int unsigned W = 1 << L;
  localparam int unsigned B = LANES * LANES * W;

  state_e       state_q, state_d;
  logic [2:0]   cnt_q, cnt_d;
  logic [B-1:0] in_q, in_d;
  logic [B-1:0] out_q, out_d;
  logic         in_ready_c, busy_c, out_valid_c;

  logic [LANES-1:0][W-1:0] slice_y;
  logic [LANES-1:0][W-1:0] slice_x;
  logic [4:0]              row_y [W];
  logic [4:0]              row_x [W];
  logic [B-1:0]            out_run;

  // Pick lanes (i, cnt) out of the captured state.
  for (genvar i = 0; i < LANES; i++) begin : g_sel
    assign slice_y[i] = (cnt_q == 3'd0) ? in_q[W*(LANES*i+0) +: W] :
                        (cnt_q == 3'd1) ? in_q[W*(LANES*i+1) +: W] :
                        (cnt_q == 3'd2) ? in_q[W*(LANES*i+2) +: W] :
                        (cnt_q == 3'd3) ? in_q[W*(LANES*i+3) +: W] :
                        (cnt_q == 3'd4) ? in_q[W*(LANES*i+4) +: W] : '0;
  end

  for (genvar k = 0; k < W; k++) begin : g_row
    assign row_y[k] = {slice_y[4][k], slice_y[3][k], slice_y[2][k],
                       slice_y[1][k], slice_y[0][k]};

    keccak_chi_inv_row u_row (
      .y_i (row_y[k]),
      .x_o (row_x[k])
    );

    for (genvar i = 0; i < LANES; i++) begin : g_bit
      assign slice_x[i][k] = row_x[k][i];
    end
  end

  // Output register image with the current slice replaced by its inverse.
  for (genvar i = 0; i < LANES; i++) begin : g_wi
    for (genvar j = 0; j < LANES; j++) begin : g_wj
      assign out_run[W*(LANES*i+j) +: W] =
        (cnt_q == 3'(j)) ? slice_x[i] : out_q[W*(LANES*i+j) +: W];
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    in_d        = in_q;
    out_d       = out_q;
    in_ready_c  = 1'b0;
    busy_c      = 1'b0;
    out_valid_c = 1'b0;
    case (state_q)
      IDLE: begin
        in_ready_c = 1'b1;
        if (bus.in_valid) begin
          in_d    = bus.in_data;
          cnt_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        busy_c = 1'b1;
        if (cnt_q > 3'd4) begin
          cnt_d   = '0;
          state_d = IDLE;
        end else begin
          out_d = out_run;
          if (cnt_q == 3'd4) begin
            cnt_d   = '0;
            state_d = DONE;
          end else begin
            cnt_d = cnt_q + 3'd1;
          end
        end
      end
      DONE: begin
        out_valid_c = 1'b1;
        if (bus.out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      in_q    <= '0;
      out_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      in_q    <= in_d;
      out_q   <= out_d;
    end
  end

  // State is IDLE during reset, so gate in_ready with rst_n to hold it low.
  assign bus.in_ready  = in_ready_c & rst_n;
  assign bus.busy      = busy_c;
  assign bus.out_valid = out_valid_c;
  assign bus.out_data  = out_q;

`ifdef KECCAK_CHI_INV_SELFCHECK_EN
  logic [B-1:0] fwd;
  logic         chk_err_q, chk_err_d;

  for (genvar i = 0; i < LANES; i++) begin : g_fi
    for (genvar j = 0; j < LANES; j++) begin : g_fj
      assign fwd[W*(LANES*i+j) +: W] = out_run[W*(LANES*i+j) +: W] ^
        (~out_run[W*(LANES*((i+1)%LANES)+j) +: W] &
          out_run[W*(LANES*((i+2)%LANES)+j) +: W]);
    end
  end

  // out_run is the complete result on the last RUN cycle, i.e. as DONE is entered.
  always_comb begin
    chk_err_d = chk_err_q;
    if (state_q == IDLE && bus.in_valid) begin
      chk_err_d = 1'b0;
    end else if (state_q == RUN && cnt_q == 3'd4) begin
      chk_err_d = (fwd != in_q);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) chk_err_q <= 1'b0;
    else        chk_err_q <= chk_err_d;
  end

  assign chk_err = chk_err_q;
`endif

endmodule

// File: doc/keccak_chi_inv.md
Name: keccak_chi_inv

Overview:
Iterative inverse of the Keccak chi step. It accepts a b-bit state y and returns x such that chi(x) = y, where chi is defined as x[i][j] ^ (~x[i+1][j] & x[i+2][j]) with indices mod 5. It processes one 5-lane slice per cycle using a 5-bit row-inverse lookup. It sits on the decrypt/analysis path beside the forward chi and uses valid/ready handshakes on both sides.

Parameters:
l, 6, log2 of lane width
w, 2**l, lane width in bits
b, 25*w, state width in bits

Ports:
clk  input  1  clock, rising edge
rst_n  input  1  asynchronous active-low reset
in_data  input  b  state to invert; lane (i,j) at bits [w*(5*i+j) +: w]
in_valid  input  1  in_data valid
in_ready  output  1  block can accept a state
out_data  output  b  inverted state, same lane layout
out_valid  output  1  out_data valid
out_ready  input  1  downstream accepts out_data
busy  output  1  high while a state is being processed

Behaviour:
- Reset is async on rst_n low. State goes to IDLE. in_ready=0 while rst_n low and 1 after release. out_valid=0, busy=0, out_data=0, slice counter=0. The input register is cleared.
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - in_ready=1.
  - When in_valid & in_ready, in_data is captured into the input register, the counter goes to 0, and the FSM moves to RUN.
- RUN:
  - in_ready=0, busy=1.
  - Each cycle, for the slice j=counter, every bit position k in 0..w-1 forms row r = {y[4][j][k], ..., y[0][j][k]} (bit i = lane i).
  - The row-inverse LUT maps r to x-row; bits are written to out_data lanes (i,j) bit k.
  - The counter increments. After j=4 is written, the FSM moves to DONE.
- DONE:
  - out_valid=1, busy=0, in_ready=0. out_data is held stable.
  - On out_ready=1 the FSM moves to IDLE and out_valid drops the next cycle.
  - out_ready high before DONE has no effect.
- Latency: accept at edge N, out_valid high after edge N+5. Minimum initiation interval is 7 cycles (accept, 5 RUN, DONE with out_ready already high, back to IDLE).
- out_data lanes are intermediate while in RUN and must not be sampled until out_valid.
- Input changes while not IDLE are ignored; in_data is consumed only on handshake.
- The counter is 3 bits, valid values 0..4, and never wraps past 4. Values 5..7 are unreachable; if reached, the FSM returns to IDLE.
- Reset mid-RUN or mid-DONE discards the operation immediately. out_valid=0 is guaranteed with no glitch past the reset edge.
- The LUT is the exact inverse of 5-bit chi and is a bijection on 32 entries. It is generated at elaboration by searching all 32 candidates through forward row-chi; there is no hand table.

Optional Feature:
KECCAK_CHI_INV_SELFCHECK_EN:
- Defined:
  - Adds output chk_err (1 bit, reset 0). In DONE, forward chi is applied to out_data and compared to the captured input.
  - chk_err is registered high on mismatch in the cycle DONE is entered and cleared on the next accept.
- Undefined: the port and logic are absent.

Decomposition:
- Package keccak_pkg:
  - lane-count constant 5
  - function row_chi(5-bit) returning 5-bit
  - function row_chi_inv(5-bit) built by exhaustive search over row_chi
  - FSM state enum typedef {IDLE, RUN, DONE}
- One sub-module keccak_chi_inv_row: a 5-bit combinational LUT wrapping row_chi_inv, instantiated w times per slice.

Test Plan:
- Reset, then in_data=0 with in_valid pulse -> out_valid after 5 cycles, out_data=0, in_ready=0 throughout.
- Lanes (0,0) and (3,0) all ones, rest 0 -> out_data lane (0,0) all ones, all other lanes 0. Forward row 00001 maps to 01001.
- All-ones state -> all-ones output; out_ready held low 10 cycles -> out_valid and out_data stable, in_ready=0.
- 1000 random states, each checked through a bench forward-chi model, with back-to-back requests and out_ready high -> exact inverse every time and initiation interval 7.
- rst_n asserted at cycle 3 of RUN -> out_valid=0 and in_ready=1 after release. The next state, lanes (0,0) and (3,0) all ones, returns the correct inverse.
- With KECCAK_CHI_INV_SELFCHECK_EN, random states -> chk_err=0 always.
